// File: rtl/mem_wb_stage_pkg.sv
//------------------------------------------------------------------------------
// mem_wb_stage_pkg : shared pipeline widths, defaults and the MEM/WB bundle.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mem_wb_stage_pkg;

   localparam int          REG_IDX_W         = 4;
   localparam int          DATA_W            = 32;
   localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

   // Writeback bundle, also consumed by the forwarding unit.
   typedef struct packed {
      logic                 wb_en;
      logic [REG_IDX_W-1:0] dest;
      logic [DATA_W-1:0]    value;
   } mem_wb_t;

endpackage

`default_nettype wire

// File: rtl/data_memory.sv
//------------------------------------------------------------------------------
// data_memory : DEPTH x 32 register array, asynchronous read, synchronous write.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module data_memory
   import mem_wb_stage_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   // Contents survive reset; no reset term on the array.
   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
//------------------------------------------------------------------------------
// mem_wb_stage : data-memory access plus MEM/WB register feeding decode writeback.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_wb_stage
   import mem_wb_stage_pkg::*;
#(
   parameter int          DEPTH     = 64,
   parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 freeze,
   input  logic                 valid_in,
   input  logic                 wb_en_in,
   input  logic                 mem_r_en_in,
   input  logic                 mem_w_en_in,
   input  logic [REG_IDX_W-1:0] dest_in,
   input  logic [DATA_W-1:0]    alu_res_in,
   input  logic [DATA_W-1:0]    val_rm_in,
   output logic                 WB_WB_EN,
   output logic [REG_IDX_W-1:0] WBDest,
   output logic [DATA_W-1:0]    WBValue,
   output logic                 mem_error,
   output logic [31:0]          retired_count
);

   localparam int          ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   logic [31:0]       w_offset;
   logic [31:0]       w_index;
   logic              w_legal;
   logic              w_active;
   logic              w_store;
   logic [DATA_W-1:0] w_rdata;
   logic [DATA_W-1:0] w_load_data;

   mem_wb_t     wb_d,    wb_q;
   logic        err_d,   err_q;
   logic [31:0] count_d, count_q;

   assign w_offset = alu_res_in - BASE_ADDR;
   assign w_index  = w_offset >> 2;
   assign w_legal  = (alu_res_in >= BASE_ADDR) && (alu_res_in[1:0] == 2'b00)
                     && (w_index < DEPTH_W);
   assign w_active = valid_in && !freeze && rst;
   assign w_store  = w_active && mem_w_en_in && w_legal;

   data_memory #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_data_memory (
      .clk     (clk),
      .we_i    (w_store),
      .waddr_i (w_index[ADDR_W-1:0]),
      .wdata_i (val_rm_in),
      .raddr_i (w_index[ADDR_W-1:0]),
      .rdata_o (w_rdata)
   );

   // Async read sees the pre-store word, which also covers load+store together.
   assign w_load_data = w_legal ? w_rdata : '0;

   always_comb begin
      wb_d    = wb_q;
      err_d   = err_q;
      count_d = count_q;
      if (!freeze) begin
         if (valid_in) begin
            wb_d.wb_en = wb_en_in;
            wb_d.dest  = dest_in;
            wb_d.value = mem_r_en_in ? w_load_data : alu_res_in;
            count_d    = count_q + 32'd1;
            if ((mem_r_en_in || mem_w_en_in) && !w_legal) begin
               err_d = 1'b1;
            end
         end else begin
            wb_d.wb_en = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wb_q    <= '0;
         err_q   <= 1'b0;
         count_q <= '0;
      end else begin
         wb_q    <= wb_d;
         err_q   <= err_d;
         count_q <= count_d;
      end
   end

   assign WB_WB_EN      = wb_q.wb_en;
   assign WBDest        = wb_q.dest;
   assign WBValue       = wb_q.value;
   assign mem_error     = err_q;
   assign retired_count = count_q;

endmodule

`default_nettype wire

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and writeback stage of the ARM pipeline: the producing end of the register-file write port that the instruction-decode stage consumes. It holds a word-addressed data memory, performs the load or store of the instruction leaving EXE, and registers the MEM/WB result. It drives the decode stage's writeback inputs (`WB_WB_EN`, `WBDest`, `WBValue`) one cycle after the instruction arrives.

## Interface
- `DEPTH`, 64: data-memory depth in 32-bit words.
- `BASE_ADDR`, 32'd1024: byte address of word 0.

Ports:
- `clk` in 1: single clock; everything is posedge.
- `rst` in 1: reset, synchronous and active-low.
- `freeze` in 1: pipeline stall. When high, all state holds.
- `valid_in` in 1: the EXE/MEM slot holds a real instruction.
- `wb_en_in` in 1: the instruction writes a register.
- `mem_r_en_in` in 1: load.
- `mem_w_en_in` in 1: store.
- `dest_in` in 4: destination register.
- `alu_res_in` in 32: ALU result, which is also the effective byte address.
- `val_rm_in` in 32: store data.
- `WB_WB_EN` out 1: register-file write enable to decode.
- `WBDest` out 4: register-file write index.
- `WBValue` out 32: register-file write data.
- `mem_error` out 1: sticky bad-address flag.
- `retired_count` out 32: number of instructions retired.

## Operation
- Address decode:
  - word index = (`alu_res_in` − `BASE_ADDR`) >> 2.
  - An access is legal iff `alu_res_in` ≥ `BASE_ADDR`, bits [1:0] = 0, and index < `DEPTH`.
- Active cycle: `valid_in` high and `freeze` low and `rst` high.
- Store: in an active cycle with `mem_w_en_in` high and a legal address, `mem[index]` ← `val_rm_in` at the edge.
- Load: combinational read of `mem[index]` within the cycle.
  - An illegal load returns 32'h0.
- MEM/WB register, captured at the edge of an active cycle:
  - `WB_WB_EN` ← `wb_en_in`
  - `WBDest` ← `dest_in`
  - `WBValue` ← (`mem_r_en_in` ? load data : `alu_res_in`)
- Bubble: a non-frozen cycle with `valid_in` low loads `WB_WB_EN` = 0. `WBDest` and `WBValue` keep their previous values.
- Frozen cycle:
  - The register, memory, counter and error flag all hold.
  - No store is performed.
  - `WB_WB_EN` keeps its value; a repeated identical register write is harmless.
- `mem_error` is set in an active cycle with (`mem_r_en_in` | `mem_w_en_in`) and an illegal address. Only reset clears it.
- `retired_count` increments by 1 in each active cycle and wraps from 32'hFFFFFFFF to 0.
- `mem_r_en_in` and `mem_w_en_in` both high is illegal input:
  - The store takes priority.
  - `WBValue` takes the pre-store memory word.
- Reset (`rst` = 0 at an edge):
  - `WB_WB_EN` = 0, `WBDest` = 0, `WBValue` = 0, `mem_error` = 0, `retired_count` = 0.
  - A store presented in that cycle is suppressed.
  - Memory contents are retained; they are not cleared by reset.
  - Reset overrides `freeze`.

## Timing
- Latency is 1 cycle: an instruction presented in cycle N appears on the writeback outputs in cycle N+1.
- Store then load of the same address in back-to-back cycles: the load in N+1 sees the data stored in N.
- A store completes at the edge ending its active cycle.
- A frozen cycle extends the latency by 1 cycle per frozen cycle.
- Memory read is asynchronous (register array). The critical path runs from the address subtractor through the memory mux to the WBValue register.

## Structure
- Shared pipeline package holds:
  - register-index width (4);
  - data width (32);
  - `BASE_ADDR` default;
  - a packed MEM/WB bundle type (`wb_en`, `dest`, `value`) reused by the future forwarding unit.
- One sub-module, `data_memory`: DEPTH×32 array with an asynchronous read port and a synchronous write port with write enable. Address legality check and the writeback mux stay in `mem_wb_stage`.

## Test plan
- Reset: hold `rst` = 0 for 2 cycles, then release → `WB_WB_EN`=0, `WBDest`=0, `WBValue`=0, `mem_error`=0, `retired_count`=0.
- ALU writeback: `valid_in`=1, `wb_en_in`=1, `dest_in`=4'd5, `alu_res_in`=32'h12345678 → next cycle `WB_WB_EN`=1, `WBDest`=5, `WBValue`=32'h12345678, `retired_count`=1.
- Store then load:
  - cycle N: store `val_rm_in`=32'hDEADBEEF to 1032;
  - cycle N+1: load from 1032 with `dest_in`=3;
  - expect in N+2: `WBDest`=3, `WBValue`=32'hDEADBEEF.
- Freeze:
  - store to 1024 with `freeze`=1 for 3 cycles, then a load of 1024;
  - expect: outputs and `retired_count` unchanged during freeze, and the load returns the old word (no write occurred).
- Illegal addresses:
  - load from 1026 (misaligned) → `WBValue`=0 and `mem_error`=1;
  - store to 1024+4·64 → memory unchanged and `mem_error` stays 1;
  - `mem_error` clears only after `rst`=0.
- Reset mid-operation: store to 1040 with `rst`=0 in the same cycle, then after release load 1040 → `WBValue` equals the pre-existing content, not the store data.
